// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and operand conditioning.
package addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Invert control for the second operand and the carry into bit 0
  typedef struct packed {
    logic inv;
    logic c0;
  } op_ctl_t;

  // SBB treats cin=1 as a pending borrow, so the carry into bit 0 is ~cin
  function automatic op_ctl_t op_ctl(input logic [1:0] op, input logic cin);
    op_ctl_t ctl;
    ctl = '0;
    case (op)
      OP_ADD:  begin ctl.inv = 1'b0; ctl.c0 = 1'b0; end
      OP_SUB:  begin ctl.inv = 1'b1; ctl.c0 = 1'b1; end
      OP_ADC:  begin ctl.inv = 1'b0; ctl.c0 = cin;  end
      default: begin ctl.inv = 1'b1; ctl.c0 = ~cin; end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             sign;
  logic             zero;
  logic             carry;
  logic             parity;
  logic             overflow;

  modport master (
    output in_valid, op, cin, A, B, out_ready,
    input  in_ready, out_valid, Y, sign, zero, carry, parity, overflow
  );

  modport slave (
    input  in_valid, op, cin, A, B, out_ready,
    output in_ready, out_valid, Y, sign, zero, carry, parity, overflow
  );
endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit adder slice with carry chain and running zero detect.
module addsub_stage #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  input  logic             zero_i,
  output logic [CHUNK-1:0] sum_c_o,
  output logic             cout_c_o,
  output logic             cmsb_c_o,
  output logic             zero_c_o
);
  logic [CHUNK:0] full_c;

  assign full_c   = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(cin_i);
  assign sum_c_o  = full_c[CHUNK-1:0];
  assign cout_c_o = full_c[CHUNK];
  // Carry into the slice MSB recovered from the MSB sum bit
  assign cmsb_c_o = full_c[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
  assign zero_c_o = zero_i & ~(|full_c[CHUNK-1:0]);
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined ADD/SUB/ADC/SBB unit: carry chain split into CHUNK-bit stages, registered result and flags.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic     clk,
  input  logic     rst,
  addsub_if.slave  bus
);
  localparam int unsigned NSTAGES = WIDTH / CHUNK;

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  op_ctl_t          ctl_c;
  logic [WIDTH-1:0] bx_c;
  logic             adv_c;

  assign ctl_c        = op_ctl(bus.op, bus.cin);
  assign bx_c         = bus.B ^ {WIDTH{ctl_c.inv}};
  assign adv_c        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv_c;

  for (genvar i = 0; i < NSTAGES; i++) begin : g_st
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             ci_c;
    logic             zi_c;
    logic             vi_c;

    // Stage inputs: from the bus for stage 0, from the previous stage register otherwise
    if (i == 0) begin : g_src
      assign a_c  = bus.A[CHUNK-1:0];
      assign b_c  = bx_c[CHUNK-1:0];
      assign ci_c = ctl_c.c0;
      assign zi_c = 1'b1;
      assign vi_c = bus.in_valid;
    end else begin : g_src
      assign a_c  = g_st[i-1].g_mid.a_q[CHUNK-1:0];
      assign b_c  = g_st[i-1].g_mid.b_q[CHUNK-1:0];
      assign ci_c = g_st[i-1].g_mid.c_q;
      assign zi_c = g_st[i-1].g_mid.z_q;
      assign vi_c = g_st[i-1].g_mid.v_q;
    end

    if (i < NSTAGES - 1) begin : g_mid
      localparam int unsigned RW = WIDTH - (i + 1) * CHUNK;
      localparam int unsigned SW = (i + 1) * CHUNK;

      logic [CHUNK-1:0] s_c;
      logic             co_c;
      logic             zo_c;
      logic             unused_cm_c;
      logic [RW-1:0]    a_d, b_d, a_q, b_q;
      logic [SW-1:0]    s_d, s_q;
      logic             c_q, z_q, v_q;

      addsub_stage #(.CHUNK(CHUNK)) u_stage (
        .a_i      (a_c),
        .b_i      (b_c),
        .cin_i    (ci_c),
        .zero_i   (zi_c),
        .sum_c_o  (s_c),
        .cout_c_o (co_c),
        .cmsb_c_o (unused_cm_c),
        .zero_c_o (zo_c)
      );

      // Remaining operand chunks and accumulated low sum move to the next stage
      if (i == 0) begin : g_fwd
        assign a_d = bus.A[WIDTH-1:CHUNK];
        assign b_d = bx_c[WIDTH-1:CHUNK];
        assign s_d = s_c;
      end else begin : g_fwd
        assign a_d = g_st[i-1].g_mid.a_q[WIDTH-i*CHUNK-1:CHUNK];
        assign b_d = g_st[i-1].g_mid.b_q[WIDTH-i*CHUNK-1:CHUNK];
        assign s_d = {s_c, g_st[i-1].g_mid.s_q};
      end

      // Intermediate stage register; shifts on advance, bubbles included
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          z_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv_c) begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= co_c;
          z_q <= zo_c;
          v_q <= vi_c;
        end
      end
    end else begin : g_last
      logic [CHUNK-1:0] s_c;
      logic             co_c;
      logic             cm_c;
      logic             zo_c;
      logic [WIDTH-1:0] y_d;
      logic [WIDTH-1:0] y_q;
      logic             sign_q, zero_q, carry_q, parity_q, overflow_q, out_valid_q;

      addsub_stage #(.CHUNK(CHUNK)) u_stage (
        .a_i      (a_c),
        .b_i      (b_c),
        .cin_i    (ci_c),
        .zero_i   (zi_c),
        .sum_c_o  (s_c),
        .cout_c_o (co_c),
        .cmsb_c_o (cm_c),
        .zero_c_o (zo_c)
      );

      if (i == 0) begin : g_res
        assign y_d = s_c;
      end else begin : g_res
        assign y_d = {s_c, g_st[i-1].g_mid.s_q};
      end

      // Output register; result and flags change only when a valid beat lands
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          y_q         <= '0;
          sign_q      <= 1'b0;
          zero_q      <= 1'b0;
          carry_q     <= 1'b0;
          parity_q    <= 1'b0;
          overflow_q  <= 1'b0;
        end else if (adv_c) begin
          out_valid_q <= vi_c;
          if (vi_c) begin
            y_q        <= y_d;
            sign_q     <= y_d[WIDTH-1];
            zero_q     <= zo_c;
            carry_q    <= co_c;
            parity_q   <= ^y_d;
            overflow_q <= cm_c ^ co_c;
          end
        end
      end

      assign bus.out_valid = out_valid_q;
      assign bus.Y         = y_q;
      assign bus.sign      = sign_q;
      assign bus.zero      = zero_q;
      assign bus.carry     = carry_q;
      assign bus.parity    = parity_q;
      assign bus.overflow  = overflow_q;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed cases, stall/reset behaviour and a random width sweep.
module tb_addsub_pipe;
  import addsub_pkg::*;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  f;   // {sign, zero, carry, parity, overflow}
  } res_t;

  typedef struct {
    int   due;
    res_t r;
  } pend_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  addsub_if #(.WIDTH(16)) b16 ();
  addsub_if #(.WIDTH(8))  b8  ();
  addsub_if #(.WIDTH(32)) b32 ();

  addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  addsub_pipe #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));
  addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input res_t obs, input res_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed y=%0h f=%b expected y=%0h f=%b", tag, obs.y, obs.f, exp.y, exp.f);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on a w-bit word
  function automatic res_t model(input int unsigned w, input logic [1:0] op, input logic cin,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, aa, bb, s, y;
    logic        c0, carry, sgn, ov;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = {32'd0, b} & mask;
    c0   = 1'b0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  begin bb = ~bb & mask; c0 = 1'b1; end
      OP_ADC:  c0 = cin;
      default: begin bb = ~bb & mask; c0 = ~cin; end
    endcase
    s     = aa + bb + 64'(c0);
    y     = s & mask;
    carry = s[w];
    sgn   = y[w-1];
    ov    = (aa[w-1] == bb[w-1]) && (y[w-1] != aa[w-1]);
    r.y   = y[31:0];
    r.f   = {sgn, (y == 64'd0), carry, ^y, ov};
    return r;
  endfunction

  function automatic res_t obs16();
    res_t r;
    r.y = 32'(b16.Y);
    r.f = {b16.sign, b16.zero, b16.carry, b16.parity, b16.overflow};
    return r;
  endfunction

  function automatic res_t obs8();
    res_t r;
    r.y = 32'(b8.Y);
    r.f = {b8.sign, b8.zero, b8.carry, b8.parity, b8.overflow};
    return r;
  endfunction

  function automatic res_t obs32();
    res_t r;
    r.y = b32.Y;
    r.f = {b32.sign, b32.zero, b32.carry, b32.parity, b32.overflow};
    return r;
  endfunction

  // One beat through the 16-bit unit with exact latency 4
  task automatic directed(input string tag, input logic [1:0] op, input logic cin,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ey, input logic [4:0] ef);
    res_t e;
    b16.op = op; b16.cin = cin; b16.A = a; b16.B = b; b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    tick();
    tick();
    chk1({tag, "_early"}, b16.out_valid, 1'b0);
    tick();
    chk1({tag, "_valid"}, b16.out_valid, 1'b1);
    e.y = 32'(ey);
    e.f = ef;
    chkr({tag, "_res"}, obs16(), e);
  endtask

  initial begin
    res_t          zr;
    res_t          held_r;
    logic          held;
    logic [1:0]    s_op [8];
    logic          s_cin[8];
    logic [15:0]   s_a  [8];
    logic [15:0]   s_b  [8];
    res_t          exp_q[$];
    pend_t         q8[$];
    pend_t         q32[$];
    pend_t         p;
    int            sent, got, sent8, sent32;

    zr = '0;
    rst = 1'b1;
    b16.in_valid = 1'b0; b16.op = OP_ADD; b16.cin = 1'b0; b16.A = '0; b16.B = '0; b16.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.op  = OP_ADD; b8.cin  = 1'b0; b8.A  = '0; b8.B  = '0; b8.out_ready  = 1'b1;
    b32.in_valid = 1'b0; b32.op = OP_ADD; b32.cin = 1'b0; b32.A = '0; b32.B = '0; b32.out_ready = 1'b1;
    #2;
    chk1("reset_out_valid", b16.out_valid, 1'b0);
    chkr("reset_result", obs16(), zr);
    chk1("reset_in_ready", b16.in_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk1("post_reset_in_ready", b16.in_ready, 1'b1);

    // Directed arithmetic and flag cases
    directed("add_ovf", OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10011);
    directed("sub_eq",  OP_SUB, 1'b0, 16'h1234, 16'h1234, 16'h0000, 5'b01100);
    directed("sub_brw", OP_SUB, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000);
    directed("adc_wrap", OP_ADC, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 5'b01100);
    directed("sbb_brw", OP_SBB, 1'b1, 16'h0005, 16'h0002, 16'h0002, 5'b00110);
    tick();

    // Back-to-back stream with a consumer stall
    for (int k = 0; k < 8; k++) begin
      s_op[k]  = 2'($urandom_range(0, 3));
      s_cin[k] = 1'($urandom_range(0, 1));
      s_a[k]   = 16'($urandom);
      s_b[k]   = 16'($urandom);
    end
    sent = 0; got = 0; held = 1'b0; held_r = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      b16.out_ready = !(c >= 3 && c <= 6);
      if (sent < 8) begin
        b16.in_valid = 1'b1;
        b16.op = s_op[sent]; b16.cin = s_cin[sent]; b16.A = s_a[sent]; b16.B = s_b[sent];
      end else begin
        b16.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk1("stall_hold_valid", b16.out_valid, 1'b1);
        chkr("stall_hold_result", obs16(), held_r);
      end
      if (b16.out_valid && !b16.out_ready)
        chk1("stall_in_ready", b16.in_ready, 1'b0);
      if (b16.out_valid && b16.out_ready) begin
        if (exp_q.size() == 0) begin
          chk1("stream_extra_beat", 1'b1, 1'b0);
        end else begin
          chkr("stream_result", obs16(), exp_q.pop_front());
        end
        got++;
      end
      held   = b16.out_valid & ~b16.out_ready;
      held_r = obs16();
      if (b16.in_valid && b16.in_ready) begin
        exp_q.push_back(model(16, s_op[sent], s_cin[sent], 32'(s_a[sent]), 32'(s_b[sent])));
        sent++;
      end
      tick();
    end
    chk1("stream_all_sent", sent == 8, 1'b1);
    chk1("stream_all_received", (got == 8) && (exp_q.size() == 0), 1'b1);
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    tick();
    tick();

    // Reset with beats in flight
    b16.op = OP_ADD; b16.cin = 1'b0; b16.A = 16'h0001; b16.B = 16'h0001;
    b16.in_valid = 1'b1;
    tick();
    tick();
    tick();
    b16.in_valid = 1'b0;
    tick();
    chk1("pre_reset_valid", b16.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_out_valid", b16.out_valid, 1'b0);
    chkr("midrst_result", obs16(), zr);
    chk1("midrst_in_ready", b16.in_ready, 1'b1);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk1("flushed_no_output", b16.out_valid, 1'b0);
    end
    chk1("after_reset_in_ready", b16.in_ready, 1'b1);

    // Random sweep on the 8/8 and 32/8 instances with exact latency
    sent8 = 0; sent32 = 0;
    for (int c = 0; c < 5000; c++) begin
      if (q8.size() != 0 && q8[0].due == c) begin
        chk1("w8_valid", b8.out_valid, 1'b1);
        p = q8.pop_front();
        chkr("w8_result", obs8(), p.r);
      end else begin
        chk1("w8_idle", b8.out_valid, 1'b0);
      end
      if (q32.size() != 0 && q32[0].due == c) begin
        chk1("w32_valid", b32.out_valid, 1'b1);
        p = q32.pop_front();
        chkr("w32_result", obs32(), p.r);
      end else begin
        chk1("w32_idle", b32.out_valid, 1'b0);
      end
      if (sent8 >= 1000 && sent32 >= 1000 && q8.size() == 0 && q32.size() == 0) break;
      b8.in_valid  = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      b8.op  = 2'($urandom_range(0, 3)); b8.cin  = 1'($urandom_range(0, 1));
      b8.A   = 8'($urandom);             b8.B    = 8'($urandom);
      b32.in_valid = (sent32 < 1000) && ($urandom_range(0, 3) != 0);
      b32.op = 2'($urandom_range(0, 3)); b32.cin = 1'($urandom_range(0, 1));
      b32.A  = $urandom;                 b32.B   = $urandom;
      #1;
      if (b8.in_valid && b8.in_ready) begin
        p.due = c + 1;
        p.r   = model(8, b8.op, b8.cin, 32'(b8.A), 32'(b8.B));
        q8.push_back(p);
        sent8++;
      end
      if (b32.in_valid && b32.in_ready) begin
        p.due = c + 4;
        p.r   = model(32, b32.op, b32.cin, b32.A, b32.B);
        q32.push_back(p);
        sent32++;
      end
      tick();
    end
    chk1("sweep_w8_complete", (sent8 == 1000) && (q8.size() == 0), 1'b1);
    chk1("sweep_w32_complete", (sent32 == 1000) && (q32.size() == 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; successor to the combinational 16-bit flag adder.
- Splits the carry chain into CHUNK-bit stages, one register per stage. Result and status flags (sign, zero, carry, parity, overflow) are registered at the output.
- Supports ADD, SUB, ADC and SBB. Uses a valid/ready handshake with full back-pressure.
- Sits between the operand/register-read logic and the writeback/flag register in the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be at least 2.
- CHUNK, 4, bits resolved per pipeline stage. WIDTH % CHUNK must equal 0, otherwise elaboration fails.
- NSTAGES, WIDTH/CHUNK, derived localparam. Equals both the pipeline latency and the depth.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin  in  1  carry input. Used only by ADC and SBB.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  result.
- sign, zero, carry, parity, overflow  out  1 each  flags belonging to Y.

Behaviour:
- Reset:
  - Asynchronous on rst=1. All stage valids, out_valid, Y and all flags go to 0. Note that zero resets to 0.
  - Applying reset mid-operation discards every in-flight beat; no partial result ever appears.
  - in_ready=1 during and after reset.
- Advance and stall:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - All stages shift together when advance=1 and hold otherwise.
  - A beat is accepted when in_valid & in_ready.
- Effective operands and carry-in:
  - ADD: Bx = B, c0 = 0.
  - SUB: Bx = ~B, c0 = 1.
  - ADC: Bx = B, c0 = cin.
  - SBB: Bx = ~B, c0 = ~cin. cin=1 means a borrow is pending.
- Pipeline stages:
  - Stage i (0..NSTAGES-1) adds chunk i of A and Bx plus the carry registered from stage i-1; stage 0 uses c0.
  - Each stage registers its partial sum chunk, its carry-out, the not-yet-consumed upper operand chunks and its valid bit.
  - Each stage also registers a running zero accumulator: all sum chunks so far are 0.
  - The last stage additionally registers the carry into the MSB for the overflow calculation.
- Latency and throughput:
  - A beat accepted on edge k appears with out_valid=1 after edge k+NSTAGES-1 (the output register is stage NSTAGES-1).
  - Latency is therefore NSTAGES cycles, including the input capture.
  - Throughput is one beat per cycle when out_ready stays 1.
  - Beat order is preserved. No beat is ever dropped or duplicated.
- Flags, all computed from the final full-width result:
  - sign = Y[WIDTH-1].
  - zero = (Y == 0).
  - parity = XOR-reduction of Y, i.e. 1 for an odd number of ones.
  - carry = raw carry-out of the MSB. For SUB/SBB, carry=1 means no borrow; it is not inverted.
  - overflow = carry into MSB XOR carry out of MSB. This matches the sign rule A/Bx-same-sign, Y-different.
- Output hold:
  - While out_valid=1 and out_ready=0, Y and all flags stay stable.
- Bubbles:
  - A bubble (stage valid=0) still shifts through the pipe. Its data is don't-care, but Y and the flags only update on edges that load a valid beat into the output stage.

Decomposition:
- Package addsub_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBB=2'b11;
  - the function that maps op and cin to the Bx invert control and c0.
- Sub-module addsub_stage: one CHUNK-bit adder slice with carry-in, sum, carry-out, carry-into-MSB, and zero-in/zero-out. It is instantiated NSTAGES times with a generate loop; the pipeline registers stay in addsub_pipe.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
1. ADD, A=16'h7FFF, B=16'h0001, out_ready=1 -> four cycles later Y=16'h8000, sign=1, zero=0, carry=0, parity=1, overflow=1.
2. SUB, A=16'h1234, B=16'h1234 -> Y=16'h0000, zero=1, carry=1, parity=0, overflow=0. Then SUB with A=16'h0000, B=16'h0001 -> Y=16'hFFFF, carry=0, sign=1, parity=0.
3. ADC, A=16'hFFFF, B=16'h0000, cin=1 -> Y=16'h0000, carry=1, zero=1. Then SBB with A=16'h0005, B=16'h0002, cin=1 -> Y=16'h0002.
4. Stream 8 random beats back-to-back while holding out_ready=0 for cycles 3-6 -> in_ready=0 throughout the stall, Y and flags stable while held, all 8 results emerge in order against the reference model, none lost.
5. Accept 3 beats, then assert rst for 1 cycle -> out_valid=0, Y=0 and all flags 0 immediately; in_ready=1 after reset; none of the pre-reset beats ever appear.
6. Parameter sweep with WIDTH=8/CHUNK=8 (latency 1) and WIDTH=32/CHUNK=8 (latency 4), 1000 random ops each -> all results and flags match the model with exact latency.
